ysyx_22041752_div_ctrl: RTL and testbench
=========================================

// Module: ysyx_22041752_div_ctrl
// PURPOSE
// - EXE-stage control unit sitting directly upstream of the unsigned core divider, which the EXE parent instantiates.
// - Accepts RV64M DIV/DIVU/REM/REMU and W-variants from EXE and converts operands to unsigned magnitudes.
// - Drives the divider, waits its latency, then applies sign fix-up and the RISC-V special cases.
// - Returns the result through a valid/ready handshake; EXE stalls on busy.
// PARAMETERS
// - DATA_W   64  operand/result width, equal to `RF_DATA_WD
// - DIV_LAT  2   cycles the core divider needs before its outputs are sampled (>=1)
// PORTS
// - clk          in   1       single clock, rising edge
// - reset_n      in   1       asynchronous, active-low reset
// - flush_i      in   1       pipeline flush; kills any in-flight op
// - div_valid_i  in   1       EXE presents a divide op
// - div_ready_o  out  1       block can accept an op (IDLE and !flush_i)
// - div_op_i     in   2       00 DIV, 01 DIVU, 10 REM, 11 REMU
// - div_word_i   in   1       W variant: operate on [31:0], sign-extend result
// - src1_i       in   DATA_W  dividend
// - src2_i       in   DATA_W  divisor
// - div_x_o      out  DATA_W  unsigned dividend magnitude to divider (registered)
// - div_y_o      out  DATA_W  unsigned divisor magnitude to divider (registered)
// - div_res_i    in   DATA_W  divider quotient
// - div_rem_i    in   DATA_W  divider remainder
// - res_valid_o  out  1       result valid
// - res_ready_i  in   1       consumer takes result
// - res_data_o   out  DATA_W  final rd value
// - busy_o       out  1       state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0; div_x_o, div_y_o, res_data_o, res_valid_o, busy_o = 0; div_ready_o=1 unless flush_i.
// - FSM: IDLE, BUSY, DONE.
// - IDLE->BUSY on div_valid_i&&div_ready_o, normal case. IDLE->DONE on accept, special case.
// - BUSY->DONE when cnt==DIV_LAT-1; quotient/remainder sampled on that edge.
// - DONE->IDLE on res_ready_i.
// - Any state->IDLE on flush_i; flush beats accept and res_ready_i, and no result is produced.
// - Operand prep at accept:
//   - word signed: sext(src[31:0]); word unsigned: zext(src[31:0]).
//   - signed ops: magnitude = src<0 ? -src : src. Capture neg_q = sign1^sign2 and neg_r = sign1.
// - Special cases, decided at accept, bypass the divider:
//   - y==0: quotient = all ones; remainder = prepared dividend.
//   - Signed overflow (dividend = most negative of the active width, divisor = -1): quotient = dividend; remainder = 0.
// - Fix-up at sample: q = neg_q ? -div_res_i : div_res_i; r = neg_r ? -div_rem_i : div_rem_i.
// - Select q or r by op[1]. Word ops: res_data_o = sext(result[31:0]).
// - Latency, from accept edge T:
//   - Normal: res_valid_o high from T+DIV_LAT+1.
//   - Special: res_valid_o high from T+1.
// - res_valid_o/res_data_o are held stable in DONE until res_ready_i. div_x_o/div_y_o are held through BUSY.
// - div_ready_o is low in BUSY/DONE; no back-to-back accept in the DONE->IDLE cycle.
// - Reset mid-operation: immediate return to reset values; the in-flight op is lost.
// STRUCTURE
// - ysyx_22041752_mycpu.vh holds the DIV_OP_* encodings (DIV/DIVU/REM/REMU) and the state encodings IDLE/BUSY/DONE.
// - Optional sub-module ysyx_22041752_div_fixup (combinational sign/word fix-up); the FSM and counter stay here.
// TESTING
// - DIV -7/2 -> res 0xFFFF_FFFF_FFFF_FFFD at T+3 (DIV_LAT=2). REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
// - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REMU 5/0 -> 0x5. Divider outputs ignored.
// - DIVW 0x8000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000. REMW same operands -> 0.
// - Backpressure: res_ready_i low 5 cycles -> res_valid_o/res_data_o stable, div_ready_o low, new div_valid_i not taken.
// - flush_i in 1st BUSY cycle -> IDLE next cycle, res_valid_o never rises. flush_i with div_valid_i in IDLE -> no accept.
// - reset_n asserted in DONE -> all outputs 0 asynchronously. After release, REMUW 0x1_0000_0007 % 3 -> 0x1.

Source files
------------

// File: rtl/ysyx_22041752_div_ctrl_pkg.sv
// Shared definitions for the EXE-stage divide control unit.
// - div_state_e : FSM states (IDLE waits for an op, BUSY waits on the core
//                 divider, DONE holds the result until it is consumed).
// - DIV_OP_*    : encodings of the div_op_i field.
// - op_is_signed / op_is_rem : decode helpers for the op field.
package ysyx_22041752_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op != DIV_OP_DIV) && (op != DIV_OP_DIVU);
  endfunction

endpackage

// File: rtl/ysyx_22041752_div_ctrl_if.sv
// Bundle of the signals between EXE, the divide control unit and the core
// divider.
// - EXE request : div_valid_i, div_ready_o, div_op_i, div_word_i, src1_i, src2_i
// - divider     : div_x_o, div_y_o (operand magnitudes), div_res_i, div_rem_i
// - EXE result  : res_valid_o, res_ready_i, res_data_o, busy_o
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may change freely and never depends on a future valid.
// modport slave is the control unit, modport master is its surroundings.
interface ysyx_22041752_div_ctrl_if #(
  parameter int DATA_W = 64
);

  logic              div_valid_i;
  logic              div_ready_o;
  logic [1:0]        div_op_i;
  logic              div_word_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [DATA_W-1:0] div_x_o;
  logic [DATA_W-1:0] div_y_o;
  logic [DATA_W-1:0] div_res_i;
  logic [DATA_W-1:0] div_rem_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic              busy_o;

  modport slave (
    input  div_valid_i, div_op_i, div_word_i, src1_i, src2_i,
    input  div_res_i, div_rem_i, res_ready_i,
    output div_ready_o, div_x_o, div_y_o, res_valid_o, res_data_o, busy_o
  );

  modport master (
    output div_valid_i, div_op_i, div_word_i, src1_i, src2_i,
    output div_res_i, div_rem_i, res_ready_i,
    input  div_ready_o, div_x_o, div_y_o, res_valid_o, res_data_o, busy_o
  );

endinterface

// File: rtl/ysyx_22041752_div_fixup.sv
// Combinational result fix-up for the divide control unit.
// - quo_i, rem_i : unsigned quotient / remainder (or special-case values)
// - neg_q_i      : negate the quotient
// - neg_r_i      : negate the remainder
// - sel_rem_i    : pick remainder instead of quotient
// - word_i       : sign-extend bit 31 of the picked value
// - res_o        : final rd value
module ysyx_22041752_div_fixup #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] rem_i,
  input  logic              neg_q_i,
  input  logic              neg_r_i,
  input  logic              sel_rem_i,
  input  logic              word_i,
  output logic [DATA_W-1:0] res_o
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] pick;

  always_comb begin
    q     = neg_q_i ? -quo_i : quo_i;
    r     = neg_r_i ? -rem_i : rem_i;
    pick  = sel_rem_i ? r : q;
    res_o = word_i ? {{(DATA_W-32){pick[31]}}, pick[31:0]} : pick;
  end

endmodule

// File: rtl/ysyx_22041752_div_ctrl.sv
// EXE-stage divide control unit in front of the unsigned core divider.
// Accepts DIV/DIVU/REM/REMU (and W forms), hands unsigned magnitudes to the
// divider, waits DIV_LAT cycles, then applies sign fix-up. Divide-by-zero and
// signed overflow are resolved at accept time without using the divider.
// - clk, reset_n : clock, asynchronous active-low reset
// - flush_i      : kills any in-flight op; beats accept and res_ready_i
// - bus          : EXE request, divider and EXE result signals (slave side)
// - state_o      : current FSM state, for observation
module ysyx_22041752_div_ctrl
  import ysyx_22041752_div_ctrl_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DIV_LAT = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_i,
  ysyx_22041752_div_ctrl_if.slave       bus,
  output div_state_e                    state_o
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);
  // Most negative value of the active width, after operand preparation.
  localparam logic [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MIN_W = {{(DATA_W-32){1'b1}}, 1'b1, 31'b0};

  div_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              ready, accept, sample, load_res;
  logic              is_signed, sign1, sign2, by_zero, ovf, special;
  logic [DATA_W-1:0] a, b, mag_a, mag_b, spec_q, spec_r;
  logic              neg_q_q, neg_r_q, rem_q, word_q;
  logic [DATA_W-1:0] div_x_q, div_y_q, res_q;
  logic              in_idle;
  logic [DATA_W-1:0] fix_quo, fix_rem, fix_res;
  logic              fix_neg_q, fix_neg_r, fix_sel_rem, fix_word;

  assign ready   = (state == IDLE) && !flush_i;
  assign accept  = bus.div_valid_i && ready;
  assign sample  = (state == BUSY) && (cnt == CNT_LAST) && !flush_i;
  assign in_idle = (state == IDLE);

  // Operand preparation and special-case detection on the incoming op.
  always_comb begin
    is_signed = op_is_signed(bus.div_op_i);
    a = bus.src1_i;
    b = bus.src2_i;
    if (bus.div_word_i) begin
      a = is_signed ? {{(DATA_W-32){bus.src1_i[31]}}, bus.src1_i[31:0]}
                    : {{(DATA_W-32){1'b0}}, bus.src1_i[31:0]};
      b = is_signed ? {{(DATA_W-32){bus.src2_i[31]}}, bus.src2_i[31:0]}
                    : {{(DATA_W-32){1'b0}}, bus.src2_i[31:0]};
    end
    sign1   = is_signed & a[DATA_W-1];
    sign2   = is_signed & b[DATA_W-1];
    mag_a   = sign1 ? -a : a;
    mag_b   = sign2 ? -b : b;
    by_zero = (b == '0);
    ovf     = is_signed && (a == (bus.div_word_i ? MIN_W : MIN_D)) && (b == '1);
    special = by_zero || ovf;
    spec_q  = by_zero ? '1 : a;
    spec_r  = by_zero ? a : '0;
  end

  // One fix-up path serves both cases: in IDLE it formats the special-case
  // values of the op being accepted, in BUSY it formats the divider outputs.
  always_comb begin
    fix_quo     = in_idle ? spec_q : bus.div_res_i;
    fix_rem     = in_idle ? spec_r : bus.div_rem_i;
    fix_neg_q   = in_idle ? 1'b0 : neg_q_q;
    fix_neg_r   = in_idle ? 1'b0 : neg_r_q;
    fix_sel_rem = in_idle ? op_is_rem(bus.div_op_i) : rem_q;
    fix_word    = in_idle ? bus.div_word_i : word_q;
  end

  ysyx_22041752_div_fixup #(.DATA_W(DATA_W)) u_fixup (
    .quo_i     (fix_quo),
    .rem_i     (fix_rem),
    .neg_q_i   (fix_neg_q),
    .neg_r_i   (fix_neg_r),
    .sel_rem_i (fix_sel_rem),
    .word_i    (fix_word),
    .res_o     (fix_res)
  );

  assign load_res = (accept && special) || sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = special ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_x_q <= '0;
      div_y_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      rem_q   <= 1'b0;
      word_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        div_x_q <= mag_a;
        div_y_q <= mag_b;
        neg_q_q <= sign1 ^ sign2;
        neg_r_q <= sign1;
        rem_q   <= op_is_rem(bus.div_op_i);
        word_q  <= bus.div_word_i;
      end
      if (load_res) res_q <= fix_res;
    end
  end

  assign bus.div_ready_o = ready;
  assign bus.div_x_o     = div_x_q;
  assign bus.div_y_o     = div_y_q;
  assign bus.res_valid_o = (state == DONE);
  assign bus.res_data_o  = res_q;
  assign bus.busy_o      = (state != IDLE);
  assign state_o         = state;

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// Bench for ysyx_22041752_div_ctrl: directed RISC-V corner cases, flush and
// reset scenarios, then randomized ops checked against an arithmetic model.
module tb_ysyx_22041752_div_ctrl;
  import ysyx_22041752_div_ctrl_pkg::*;

  localparam int DATA_W  = 64;
  localparam int DIV_LAT = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush_i = 1'b0;
  div_state_e state_o;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] junk = '0;
  int dv_cnt = 0;

  ysyx_22041752_div_ctrl_if #(.DATA_W(DATA_W)) bus ();

  ysyx_22041752_div_ctrl #(.DATA_W(DATA_W), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Core divider stand-in: real results only once the operands have been
  // held for DIV_LAT cycles, junk otherwise (and for a zero divisor).
  always @(posedge clk) dv_cnt <= bus.busy_o ? dv_cnt + 1 : 0;

  always_comb begin
    if (bus.div_y_o != 0 && dv_cnt >= DIV_LAT - 1) begin
      bus.div_res_i = bus.div_x_o / bus.div_y_o;
      bus.div_rem_i = bus.div_x_o % bus.div_y_o;
    end else begin
      bus.div_res_i = junk;
      bus.div_rem_i = ~junk;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V M-extension semantics in plain integer arithmetic.
  task automatic model(input logic [1:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat,
                       output logic [63:0] mx, output logic [63:0] my);
    bit sgn, rem, special;
    int sa, sb;
    int unsigned ua, ub;
    logic [31:0] r32;
    longint la, lb;
    longint unsigned ula, ulb;
    sgn = (op[0] == 1'b0);
    rem = op[1];
    special = 1'b1;
    if (word) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (ub == 0) r32 = rem ? ua : 32'hFFFF_FFFF;
      else if (sgn && sa == int'(32'h8000_0000) && sb == -1) r32 = rem ? 32'h0 : ua;
      else begin
        special = 1'b0;
        if (sgn) r32 = rem ? sa % sb : sa / sb;
        else     r32 = rem ? ua % ub : ua / ub;
      end
      res = {{32{r32[31]}}, r32};
      la = sa; lb = sb;
      mx = sgn ? (la < 0 ? -la : la) : {32'h0, ua};
      my = sgn ? (lb < 0 ? -lb : lb) : {32'h0, ub};
    end else begin
      la = a; lb = b; ula = a; ulb = b;
      if (b == 0) res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        res = rem ? 64'h0 : a;
      else begin
        special = 1'b0;
        if (sgn) res = rem ? la % lb : la / lb;
        else     res = rem ? ula % ulb : ula / ulb;
      end
      mx = sgn ? (la < 0 ? -la : la) : a;
      my = sgn ? (lb < 0 ? -lb : lb) : b;
    end
    lat = special ? 1 : DIV_LAT + 1;
  endtask

  function automatic logic [63:0] pick_val();
    logic signed [63:0] s;
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: begin
        s = $urandom_range(0, 40);
        s = s - 20;
        return s;
      end
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issue one op from IDLE, check latency, operands and result, optionally
  // hold res_ready_i low for `hold` cycles while offering another op.
  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat,
                        input logic [63:0] exp_x, input logic [63:0] exp_y, input int hold);
    int lat;
    exp_q.push_back(exp_res);
    junk = {$urandom, $urandom};
    bus.div_op_i    = op;
    bus.div_word_i  = word;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.div_valid_i = 1'b1;
    #1;
    check("ready_idle", bus.div_ready_o, 1);
    tick();
    bus.div_valid_i = 1'b0;
    lat = 1;
    if (exp_lat > 1) begin
      check("busy_after_accept", bus.busy_o, 1);
      check("div_x", bus.div_x_o, exp_x);
      check("div_y", bus.div_y_o, exp_y);
    end
    while (!bus.res_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", bus.res_data_o, exp_q[0]);
    for (int i = 0; i < hold; i++) begin
      bus.div_valid_i = 1'b1;
      bus.src1_i      = {$urandom, $urandom};
      tick();
      check("hold_valid", bus.res_valid_o, 1);
      check("hold_data", bus.res_data_o, exp_q[0]);
      check("hold_ready_low", bus.div_ready_o, 0);
      check("hold_state", state_o, DONE);
    end
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    bus.div_valid_i = 1'b0;
    check("release_idle", bus.busy_o, 0);
    void'(exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r, mx, my, a, b;
    logic [1:0]  op;
    logic        word;
    int          lat;

    bus.div_valid_i = 1'b0;
    bus.div_op_i    = 2'b00;
    bus.div_word_i  = 1'b0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.res_ready_i = 1'b0;

    // Reset values
    #1;
    check("rst_res_valid", bus.res_valid_o, 0);
    check("rst_res_data", bus.res_data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_div_x", bus.div_x_o, 0);
    check("rst_div_y", bus.div_y_o, 0);
    check("rst_ready", bus.div_ready_o, 1);
    check("rst_state", state_o, IDLE);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Directed RISC-V cases; REM also exercises 5 cycles of backpressure
    run_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 3, 64'd7, 64'd2, 0);
    run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'd7, 64'd2, 5);
    run_op(2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 64'd0, 0);
    run_op(2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1, 64'd0, 64'd0, 0);
    run_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 64'd0, 64'd0, 0);
    run_op(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 64'd0, 64'd0, 0);

    // Flush in the first BUSY cycle
    bus.div_op_i = 2'b00; bus.div_word_i = 1'b0;
    bus.src1_i = 64'd100; bus.src2_i = 64'd7;
    bus.div_valid_i = 1'b1;
    tick();
    bus.div_valid_i = 1'b0;
    check("flush_busy_before", bus.busy_o, 1);
    flush_i = 1'b1;
    #1;
    check("flush_ready_low", bus.div_ready_o, 0);
    tick();
    flush_i = 1'b0;
    check("flush_to_idle", state_o, IDLE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_result", bus.res_valid_o, 0);
    end

    // Flush together with div_valid_i in IDLE
    bus.div_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("flush_idle_ready", bus.div_ready_o, 0);
    tick();
    bus.div_valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_idle_no_accept", bus.busy_o, 0);

    // Reset while holding a result in DONE
    bus.div_op_i = 2'b01; bus.div_word_i = 1'b0;
    bus.src1_i = 64'd5; bus.src2_i = 64'd0;
    bus.div_valid_i = 1'b1;
    tick();
    bus.div_valid_i = 1'b0;
    check("pre_reset_done", state_o, DONE);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_res_valid", bus.res_valid_o, 0);
    check("arst_res_data", bus.res_data_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_div_x", bus.div_x_o, 0);
    check("arst_div_y", bus.div_y_o, 0);
    check("arst_ready", bus.div_ready_o, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_op(2'b11, 1'b1, 64'h1_0000_0007, 64'd3, 64'd1, 3, 64'd7, 64'd3, 0);

    // Randomized ops against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      op   = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      a    = pick_val();
      b    = pick_val();
      model(op, word, a, b, r, lat, mx, my);
      run_op(op, word, a, b, r, lat, mx, my, $urandom_range(0, 2));
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
